input_loader: RTL and testbench

INPUT_LOADER -- requirements
Module: input_loader

---
 rtl/input_loader.sv | 89 ++++++++
 tb/tb_input_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_loader.sv
// Byte-stream loader: assembles the binary image and layer-one weights from an
// 8-bit valid-qualified stream while the top level sits in the load phase.
module input_loader #(
   parameter int unsigned PIX_BYTES = 98,
   parameter int unsigned WT_BYTES  = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             state,
   input  logic [7:0]             data_in,
   input  logic                   data_valid,
   output logic                   data_ready,
   output logic [8*PIX_BYTES-1:0] pixels,
   output logic [8*WT_BYTES-1:0]  weights,
   output logic [7:0]             checksum,
   output logic                   load_done
);

   localparam int unsigned        CNT_W  = 7;
   localparam logic [2:0]         S_LOAD = 3'b001;
   localparam logic [CNT_W-1:0]   LAST   = CNT_W'(PIX_BYTES + WT_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DONE
   } fsm_t;

   fsm_t             fsm;
   logic [CNT_W-1:0] cnt;

   // data_ready and load_done are kept as registered mirrors of RECV and DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= IDLE;
         cnt        <= '0;
         pixels     <= '0;
         weights    <= '0;
         checksum   <= '0;
         data_ready <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (state == S_LOAD) begin
                  fsm        <= RECV;
                  cnt        <= '0;
                  checksum   <= '0;
                  data_ready <= 1'b1;
               end
            end
            RECV: begin
               if (state != S_LOAD) begin
                  fsm        <= IDLE;
                  data_ready <= 1'b0;
               end else if (data_valid && data_ready) begin
                  // Byte index selects the destination lane, pixels first then weights.
                  for (int unsigned i = 0; i < PIX_BYTES; i++) begin
                     if (cnt == CNT_W'(i)) pixels[8*i +: 8] <= data_in;
                  end
                  for (int unsigned j = 0; j < WT_BYTES; j++) begin
                     if (cnt == CNT_W'(PIX_BYTES + j)) weights[8*j +: 8] <= data_in;
                  end
                  checksum <= checksum ^ data_in;
                  if (cnt == LAST) begin
                     fsm        <= DONE;
                     data_ready <= 1'b0;
                     load_done  <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (state != S_LOAD) begin
                  fsm       <= IDLE;
                  load_done <= 1'b0;
               end
            end
            default: begin
               fsm        <= IDLE;
               data_ready <= 1'b0;
               load_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_loader.sv
// Randomised and directed bench for input_loader against a byte-array model of the load.
module tb_input_loader;

   localparam int unsigned PIX_BYTES = 98;
   localparam int unsigned WT_BYTES  = 9;
   localparam int unsigned TOTAL     = PIX_BYTES + WT_BYTES;
   localparam logic [2:0]  S_LOAD    = 3'b001;
   localparam logic [2:0]  S_IDLE    = 3'b000;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [2:0]             state;
   logic [7:0]             data_in;
   logic                   data_valid;
   logic                   data_ready;
   logic [8*PIX_BYTES-1:0] pixels;
   logic [8*WT_BYTES-1:0]  weights;
   logic [7:0]             checksum;
   logic                   load_done;

   always #5 clk = ~clk;

   input_loader #(.PIX_BYTES(PIX_BYTES), .WT_BYTES(WT_BYTES)) dut (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .pixels     (pixels),
      .weights    (weights),
      .checksum   (checksum),
      .load_done  (load_done)
   );

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   // Model: whether a load is in progress or complete, next byte index, stored bytes.
   bit         m_loading;
   bit         m_done;
   int         m_k;
   logic [7:0] m_pix [PIX_BYTES];
   logic [7:0] m_wt  [WT_BYTES];
   logic [7:0] m_chk;

   task automatic check(input string name, input logic [783:0] act, input logic [783:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [8*PIX_BYTES-1:0] exp_pixels();
      logic [8*PIX_BYTES-1:0] r;
      for (int i = 0; i < int'(PIX_BYTES); i++) r[8*i +: 8] = m_pix[i];
      return r;
   endfunction

   function automatic logic [8*WT_BYTES-1:0] exp_weights();
      logic [8*WT_BYTES-1:0] r;
      for (int i = 0; i < int'(WT_BYTES); i++) r[8*i +: 8] = m_wt[i];
      return r;
   endfunction

   // Advance the model by one clock edge using the inputs presented at that edge.
   task automatic model_step();
      if (rst) begin
         m_loading = 1'b0;
         m_done    = 1'b0;
         m_k       = 0;
         m_chk     = 8'h00;
         for (int i = 0; i < int'(PIX_BYTES); i++) m_pix[i] = 8'h00;
         for (int i = 0; i < int'(WT_BYTES); i++) m_wt[i] = 8'h00;
      end else if (m_loading) begin
         if (state != S_LOAD) begin
            m_loading = 1'b0;
         end else if (data_valid) begin
            if (m_k < int'(PIX_BYTES)) m_pix[m_k] = data_in;
            else m_wt[m_k - int'(PIX_BYTES)] = data_in;
            m_chk = m_chk ^ data_in;
            m_k++;
            if (m_k == int'(TOTAL)) begin
               m_loading = 1'b0;
               m_done    = 1'b1;
            end
         end
      end else if (m_done) begin
         if (state != S_LOAD) m_done = 1'b0;
      end else if (state == S_LOAD) begin
         m_loading = 1'b1;
         m_k       = 0;
         m_chk     = 8'h00;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      data_in    = b;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
   endtask

   task automatic enter();
      state = S_LOAD;
      step();
   endtask

   task automatic leave();
      data_valid = 1'b0;
      state      = S_IDLE;
      step();
      step();
   endtask

   // Single compare process: every output against the model, every cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("data_ready", 784'(data_ready), 784'(m_loading));
         check("load_done", 784'(load_done), 784'(m_done));
         check("checksum", 784'(checksum), 784'(m_chk));
         check("pixels", 784'(pixels), 784'(exp_pixels()));
         check("weights", 784'(weights), 784'(exp_weights()));
      end
   end

   initial begin
      rst        = 1'b1;
      state      = S_IDLE;
      data_in    = 8'h00;
      data_valid = 1'b0;
      step();
      step();
      cmp_en = 1'b1;
      check("reset_pixels", 784'(pixels), 784'(0));
      check("reset_ready", 784'(data_ready), 784'(0));
      rst = 1'b0;
      step();

      // All-ones image, all-zero weights, gap-free.
      enter();
      for (int k = 0; k < int'(PIX_BYTES); k++) send(8'hFF);
      for (int k = 0; k < int'(WT_BYTES); k++) send(8'h00);
      check("ones_pixels", 784'(pixels), 784'({PIX_BYTES{8'hFF}}));
      check("ones_weights", 784'(weights), 784'(0));
      check("ones_checksum", 784'(checksum), 784'(8'h00));
      check("ones_done", 784'(load_done), 784'(1));
      check("ones_ready", 784'(data_ready), 784'(0));
      leave();
      check("ones_done_fell", 784'(load_done), 784'(0));

      // Counting pattern, gap-free.
      enter();
      for (int k = 0; k < int'(TOTAL); k++) send(8'(k));
      check("count_pix1", 784'(pixels[15:8]), 784'(8'h01));
      check("count_wt0", 784'(weights[7:0]), 784'(8'h62));
      check("count_wt8", 784'(weights[71:64]), 784'(8'h6A));
      check("count_checksum", 784'(checksum), 784'(8'h6B));
      leave();

      // Counting pattern with a 3-cycle valid gap before every 4th byte.
      enter();
      for (int k = 0; k < int'(TOTAL); k++) begin
         if (k % 4 == 3) begin
            for (int g = 0; g < 3; g++) begin
               data_in = 8'($urandom);
               step();
            end
         end
         send(8'(k));
         if (k == int'(TOTAL) - 2) check("gap_not_done_early", 784'(load_done), 784'(0));
      end
      check("gap_pix1", 784'(pixels[15:8]), 784'(8'h01));
      check("gap_wt0", 784'(weights[7:0]), 784'(8'h62));
      check("gap_wt8", 784'(weights[71:64]), 784'(8'h6A));
      check("gap_checksum", 784'(checksum), 784'(8'h6B));
      check("gap_done", 784'(load_done), 784'(1));
      leave();

      // Abort after byte 50, bytes offered while idle, then a full 0xA5 load.
      enter();
      for (int k = 0; k <= 50; k++) send(8'($urandom));
      state = S_IDLE;
      step();
      check("abort_done", 784'(load_done), 784'(0));
      send(8'h3C);
      send(8'hC3);
      check("abort_done_idle", 784'(load_done), 784'(0));
      check("abort_ready_idle", 784'(data_ready), 784'(0));
      enter();
      for (int k = 0; k < int'(TOTAL); k++) send(8'hA5);
      check("a5_pixels", 784'(pixels), 784'({PIX_BYTES{8'hA5}}));
      check("a5_weights", 784'(weights), 784'({WT_BYTES{8'hA5}}));
      check("a5_checksum", 784'(checksum), 784'(8'hA5));

      // Bytes offered while complete must be ignored.
      for (int c = 0; c < 10; c++) begin
         data_in    = 8'h00;
         data_valid = 1'b1;
         step();
         check("done_ready", 784'(data_ready), 784'(0));
         check("done_hold_pix", 784'(pixels), 784'({PIX_BYTES{8'hA5}}));
         check("done_hold_chk", 784'(checksum), 784'(8'hA5));
      end
      leave();

      // Reset mid-load with a byte presented on the reset edge.
      enter();
      for (int k = 0; k <= 60; k++) send(8'($urandom_range(1, 255)));
      rst        = 1'b1;
      data_valid = 1'b1;
      data_in    = 8'h77;
      step();
      rst        = 1'b0;
      data_valid = 1'b0;
      check("rst_pixels", 784'(pixels), 784'(0));
      check("rst_weights", 784'(weights), 784'(0));
      check("rst_checksum", 784'(checksum), 784'(0));
      check("rst_ready", 784'(data_ready), 784'(0));
      check("rst_done", 784'(load_done), 784'(0));
      step();
      check("rst_restart_ready", 784'(data_ready), 784'(1));
      for (int k = 0; k < int'(TOTAL); k++) send(8'($urandom));
      check("rst_reload_done", 784'(load_done), 784'(1));
      leave();

      // Random phase changes, valid patterns, data and occasional resets.
      for (int c = 0; c < 4000; c++) begin
         rst        = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 249) == 0) state = (state == S_LOAD) ? 3'($urandom_range(2, 7)) : S_LOAD;
         data_valid = ($urandom_range(0, 3) != 0);
         data_in    = 8'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
